regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 151 +++++++++++++++
 tb/tb_regfile_mp.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with a clear sweep and a busy scoreboard.
//
// After reset, or on i_clr, the block walks every register and writes zero,
// one per cycle. Only then does it accept writes (o_ready=1).
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous reset, active low
//   i_clr    start a zeroing sweep (ignored while a sweep is running)
//   i_wen    per write port enable
//   i_waddr  packed write addresses, port k at [k*AW +: AW]
//   i_wdata  packed write data, port k at [k*XLEN +: XLEN]
//   i_raddr  packed read addresses
//   o_rdata  packed combinational read data
//   i_bset   mark register i_baddr busy
//   i_baddr  scoreboard set address
//   o_busy   busy bit of each read address
//   o_ready  sweep complete, writes accepted
//
// state | meaning
// CLEAR | sweeping: writes zero to register cnt each cycle, user ops ignored
// READY | normal operation: writes, reads, scoreboard updates
module regfile_mp #(
  parameter int XLEN   = 64,
  parameter int NREG   = 32,
  parameter int NRP    = 2,
  parameter int NWP    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_clr,
  input  logic [NWP-1:0]      i_wen,
  input  logic [NWP*AW-1:0]   i_waddr,
  input  logic [NWP*XLEN-1:0] i_wdata,
  input  logic [NRP*AW-1:0]   i_raddr,
  output logic [NRP*XLEN-1:0] o_rdata,
  input  logic                i_bset,
  input  logic [AW-1:0]       i_baddr,
  output logic [NRP-1:0]      o_busy,
  output logic                o_ready
);

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_e;

  state_e            state_q;
  state_e            state_nxt;
  logic [AW-1:0]     cnt_q;
  logic [XLEN-1:0]   regs [NREG];
  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_nxt;
  logic [AW-1:0]     waddr [NWP];
  logic [XLEN-1:0]   wdata [NWP];
  logic [NWP-1:0]    wr_ok;
  logic              bset_ok;

  // state register; cnt only advances in CLEAR so it is 0 whenever a sweep starts
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= (state_q == CLEAR) ? cnt_q + AW'(1) : '0;
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      CLEAR:   if (cnt_q == AW'(NREG - 1)) state_nxt = READY;
      READY:   if (i_clr) state_nxt = CLEAR;
      default: state_nxt = CLEAR;
    endcase
  end

  always_comb begin
    o_ready = (state_q == READY);
  end

  // unpack write ports; a write to r0 never counts as a write
  always_comb begin
    for (int k = 0; k < NWP; k++) begin
      waddr[k] = i_waddr[k*AW +: AW];
      wdata[k] = i_wdata[k*XLEN +: XLEN];
      wr_ok[k] = o_ready && i_wen[k] && (waddr[k] != '0);
    end
    bset_ok = o_ready && i_bset && (i_baddr != '0);
  end

  // array has no reset; the sweep zeroes it. Later ports overwrite earlier
  // ones in the loop, so the highest-index port wins on an address clash.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      regs[cnt_q] <= '0;
    end else begin
      for (int k = 0; k < NWP; k++) begin
        if (wr_ok[k]) regs[waddr[k]] <= wdata[k];
      end
    end
  end

  // write clears, set applied last so it wins over a same-cycle clear
  always_comb begin
    busy_nxt = busy_q;
    for (int k = 0; k < NWP; k++) begin
      if (wr_ok[k]) busy_nxt[waddr[k]] = 1'b0;
    end
    if (bset_ok) busy_nxt[i_baddr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
    end else if (!o_ready || i_clr) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_nxt;
    end
  end

  always_comb begin
    o_rdata = '0;
    o_busy  = '0;
    for (int p = 0; p < NRP; p++) begin : g_rd
      logic [AW-1:0]   ra;
      logic [XLEN-1:0] d;
      logic            b;
      ra = i_raddr[p*AW +: AW];
      d  = regs[ra];
      b  = busy_q[ra];
      if (BYPASS != 0) begin
        for (int k = 0; k < NWP; k++) begin
          if (wr_ok[k] && (waddr[k] == ra)) begin
            d = wdata[k];
            if (!(bset_ok && (i_baddr == ra))) b = 1'b0;
          end
        end
      end
      if (!o_ready || (ra == '0)) begin
        d = '0;
        b = 1'b0;
      end
      o_rdata[p*XLEN +: XLEN] = d;
      o_busy[p]               = b;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic           clr;
  logic [1:0]     wen;
  logic [2*AW-1:0]   waddr;
  logic [2*XLEN-1:0] wdata;
  logic [2*AW-1:0]   raddr;
  logic           bset;
  logic [AW-1:0]  baddr;

  logic [2*XLEN-1:0] rdata_b, rdata_n;
  logic [1:0]        busy_b, busy_n;
  logic              ready_b, ready_n;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRP(2), .NWP(2), .BYPASS(1)) u_dut_byp (
    .clk(clk), .rst(rst), .i_clr(clr), .i_wen(wen), .i_waddr(waddr), .i_wdata(wdata),
    .i_raddr(raddr), .o_rdata(rdata_b), .i_bset(bset), .i_baddr(baddr),
    .o_busy(busy_b), .o_ready(ready_b)
  );

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRP(2), .NWP(2), .BYPASS(0)) u_dut_nob (
    .clk(clk), .rst(rst), .i_clr(clr), .i_wen(wen), .i_waddr(waddr), .i_wdata(wdata),
    .i_raddr(raddr), .o_rdata(rdata_n), .i_bset(bset), .i_baddr(baddr),
    .o_busy(busy_n), .o_ready(ready_n)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen  = '0;
    bset = 1'b0;
    clr  = 1'b0;
  endtask

  // ready must stay low for exactly NREG edges, then rise
  task automatic sweep_check(input string tag);
    for (int i = 0; i < NREG; i++) begin
      chk({tag, "_low"}, ready_b, 0);
      step();
    end
    chk({tag, "_rise_byp"}, ready_b, 1);
    chk({tag, "_rise_nob"}, ready_n, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    idle();
    waddr = '0;
    wdata = '0;
    raddr = '0;
    baddr = '0;
    #3;
    chk("rst_ready", ready_b, 0);
    chk("rst_rdata0", rdata_b[63:0], 0);
    chk("rst_rdata1", rdata_b[127:64], 0);
    chk("rst_busy", busy_b, 0);
    repeat (3) step();
    rst = 1'b1;
    sweep_check("init_sweep");

    for (int a = 0; a < NREG; a++) begin
      raddr = {AW'(a), AW'(a)};
      #1;
      chk("init_read_byp", rdata_b[63:0], 0);
      chk("init_read_nob", rdata_n[127:64], 0);
    end

    // same-cycle forwarding of a port 0 write to port 1
    raddr[9:5]  = 5'd5;
    wen         = 2'b01;
    waddr[4:0]  = 5'd5;
    wdata[63:0] = 64'hDEAD_BEEF;
    #1;
    chk("fwd_byp_same", rdata_b[127:64], 64'hDEAD_BEEF);
    chk("fwd_nob_same", rdata_n[127:64], 0);
    step();
    idle();
    #1;
    chk("fwd_byp_after", rdata_b[127:64], 64'hDEAD_BEEF);
    chk("fwd_nob_after", rdata_n[127:64], 64'hDEAD_BEEF);

    // write-port priority and r0 discard
    wen   = 2'b11;
    waddr = {5'd7, 5'd7};
    wdata = {64'h22, 64'h11};
    raddr[4:0] = 5'd7;
    #1;
    chk("prio_byp_same", rdata_b[63:0], 64'h22);
    step();
    idle();
    #1;
    chk("prio_byp_after", rdata_b[63:0], 64'h22);
    chk("prio_nob_after", rdata_n[63:0], 64'h22);
    wen         = 2'b01;
    waddr[4:0]  = 5'd0;
    wdata[63:0] = 64'h33;
    raddr[4:0]  = 5'd0;
    #1;
    chk("r0_byp_same", rdata_b[63:0], 0);
    step();
    idle();
    #1;
    chk("r0_byp_after", rdata_b[63:0], 0);
    chk("r0_nob_after", rdata_n[63:0], 0);
    chk("r5_intact", rdata_n[127:64], 64'hDEAD_BEEF);

    // scoreboard
    bset  = 1'b1;
    baddr = 5'd9;
    step();
    idle();
    raddr[4:0] = 5'd9;
    #1;
    chk("busy_set_byp", busy_b[0], 1);
    chk("busy_set_nob", busy_n[0], 1);
    wen           = 2'b10;
    waddr[9:5]    = 5'd9;
    wdata[127:64] = 64'h99;
    #1;
    chk("busy_fwd_byp", busy_b[0], 0);
    chk("busy_fwd_nob", busy_n[0], 1);
    step();
    idle();
    #1;
    chk("busy_clr_byp", busy_b[0], 0);
    chk("busy_clr_nob", busy_n[0], 0);
    chk("r9_data", rdata_n[63:0], 64'h99);
    bset       = 1'b1;
    baddr      = 5'd9;
    wen        = 2'b01;
    waddr[4:0] = 5'd9;
    step();
    idle();
    #1;
    chk("busy_setwins_byp", busy_b[0], 1);
    chk("busy_setwins_nob", busy_n[0], 1);
    bset  = 1'b1;
    baddr = 5'd0;
    raddr[9:5] = 5'd0;
    step();
    idle();
    #1;
    chk("busy_r0", busy_b[1], 0);
    bset  = 1'b1;
    baddr = 5'd12;
    step();
    idle();

    // clear sweep from READY
    wen         = 2'b01;
    waddr[4:0]  = 5'd3;
    wdata[63:0] = 64'h44;
    step();
    idle();
    raddr = {5'd12, 5'd3};
    #1;
    chk("r3_pre_clr", rdata_n[63:0], 64'h44);
    chk("r12_busy_pre", busy_b[1], 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    #1;
    chk("clr_ready", ready_b, 0);
    chk("clr_rdata", rdata_b[63:0], 0);
    chk("clr_busy", busy_b[1], 0);
    for (int i = 0; i < NREG - 1; i++) begin
      wen   = 2'b11;
      waddr = {5'd3, 5'd3};
      wdata = {64'h66, 64'h55};
      bset  = 1'b1;
      baddr = 5'd3;
      clr   = 1'b1;
      chk("clr_sweep_low", ready_b, 0);
      step();
    end
    idle();
    chk("clr_sweep_last", ready_b, 0);
    step();
    chk("clr_done_byp", ready_b, 1);
    chk("clr_done_nob", ready_n, 1);
    raddr = {5'd3, 5'd3};
    #1;
    chk("r3_post_clr", rdata_n[63:0], 0);
    chk("r3_busy_post", busy_b[1], 0);
    raddr = {5'd12, 5'd9};
    #1;
    chk("r9_busy_post", busy_n[0], 0);
    chk("r12_busy_post", busy_n[1], 0);
    chk("r9_data_post", rdata_n[63:0], 0);
    raddr[4:0] = 5'd5;
    #1;
    chk("r5_data_post", rdata_n[63:0], 0);

    // reset mid-sweep
    wen         = 2'b01;
    waddr[4:0]  = 5'd5;
    wdata[63:0] = 64'hAB;
    step();
    idle();
    #1;
    chk("r5_ab", rdata_b[63:0], 64'hAB);
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (10) step();
    wen         = 2'b01;
    wdata[63:0] = 64'hCD;
    bset        = 1'b1;
    baddr       = 5'd5;
    rst         = 1'b0;
    #1;
    chk("mid_rst_ready", ready_b, 0);
    chk("mid_rst_rdata", rdata_b[63:0], 0);
    chk("mid_rst_busy", busy_b, 0);
    repeat (2) step();
    idle();
    rst = 1'b1;
    sweep_check("restart_sweep");
    #1;
    chk("r5_after_restart", rdata_n[63:0], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
